// File: rtl/ide_sizer.sv
// ide_sizer: splits a 32-bit CPU bus cycle into one or two 16-bit IDE
// sub-cycles. It strobes the IDE timing engine and steers write/read data
// between the 32-bit CPU bus and the 16-bit IDE bus. It then acknowledges
// the CPU, or signals a bus error if the engine never answers.
//
// Ports
//   CLK, RESET   clock, asynchronous active-high reset
//   TS, RW, A, SIZ, ACCESS, D   CPU cycle request (TS, ACCESS active low)
//   DIDE, ATA    IDE read data and engine acknowledge (ATA active low)
//   ATS, AA1     engine start strobe (active low) and word-select bit
//   WDIDE        IDE write data
//   DOUT         CPU read data
//   CPUTA, BERR  CPU acknowledge / bus error (active low, one cycle)
//   BUSY         high while a transfer is in progress
module ide_sizer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TS,
    input  logic        RW,
    input  logic [31:0] A,
    input  logic [1:0]  SIZ,
    input  logic        ACCESS,
    input  logic [31:0] D,
    input  logic [15:0] DIDE,
    input  logic        ATA,
    output logic        ATS,
    output logic        AA1,
    output logic [15:0] WDIDE,
    output logic [31:0] DOUT,
    output logic        CPUTA,
    output logic        BERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {IDLE, CYC1, GAP, CYC2, ACK, ERR} state_t;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

    state_t      state_q;
    logic        split_q;
    logic        rw_q;
    logic [7:0]  wd_q;
    logic        ats_q;
    logic        aa1_q;
    logic [15:0] wdide_q;
    logic [31:0] dout_q;
    logic        cputa_q;
    logic        berr_q;
    logic        busy_q;

    logic       split_d;
    logic [8:0] wd_d;
    logic       expire;
    logic       unused_ok;

    // A cycle needs two IDE words when it starts in the upper word and
    // reaches into the lower one.
    assign split_d = ~A[1] & ((SIZ == 2'b00) | (SIZ == 2'b11) | ((SIZ == 2'b10) & A[0]));

    // Watchdog count after this cycle; expiry only matters when ATA is high,
    // so an acknowledge on the expiry cycle still completes normally.
    assign wd_d   = {1'b0, wd_q} + 9'd1;
    assign expire = (wd_d >= TO_LIM);

    assign unused_ok = ^{A[31:2]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            split_q <= 1'b0;
            rw_q    <= 1'b0;
            wd_q    <= 8'd0;
            ats_q   <= 1'b1;
            aa1_q   <= 1'b0;
            wdide_q <= 16'd0;
            dout_q  <= 32'd0;
            cputa_q <= 1'b1;
            berr_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses unless a branch below asserts them.
            ats_q   <= 1'b1;
            cputa_q <= 1'b1;
            berr_q  <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!TS && !ACCESS) begin
                        state_q <= CYC1;
                        split_q <= split_d;
                        rw_q    <= RW;
                        aa1_q   <= A[1];
                        ats_q   <= 1'b0;
                        wd_q    <= 8'd0;
                        wdide_q <= A[1] ? D[15:0] : D[31:16];
                        busy_q  <= 1'b1;
                    end
                end
                CYC1, CYC2: begin
                    if (!ATA) begin
                        if (rw_q) begin
                            if (aa1_q) dout_q[15:0]  <= DIDE;
                            else       dout_q[31:16] <= DIDE;
                        end
                        if (state_q == CYC1 && split_q) begin
                            state_q <= GAP;
                            aa1_q   <= 1'b1;
                        end else begin
                            state_q <= ACK;
                            cputa_q <= 1'b0;
                        end
                    end else if (expire) begin
                        state_q <= ERR;
                        berr_q  <= 1'b0;
                    end else begin
                        wd_q <= wd_d[7:0];
                    end
                end
                // One dead cycle lets the engine release ATA before the next strobe.
                GAP: begin
                    state_q <= CYC2;
                    ats_q   <= 1'b0;
                    wd_q    <= 8'd0;
                    wdide_q <= D[15:0];
                end
                ACK, ERR: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ATS   = ats_q;
    assign AA1   = aa1_q;
    assign WDIDE = wdide_q;
    assign DOUT  = dout_q;
    assign CPUTA = cputa_q;
    assign BERR  = berr_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ide_sizer.sv
module tb_ide_sizer;

    logic        CLK = 1'b0;
    logic        RESET, TS, RW, ACCESS, ATA;
    logic [31:0] A, D;
    logic [1:0]  SIZ;
    logic [15:0] DIDE;
    logic        ATS, AA1, CPUTA, BERR, BUSY;
    logic [15:0] WDIDE;
    logic [31:0] DOUT;

    ide_sizer #(.TIMEOUT(255)) dut (
        .CLK(CLK), .RESET(RESET), .TS(TS), .RW(RW), .A(A), .SIZ(SIZ),
        .ACCESS(ACCESS), .D(D), .DIDE(DIDE), .ATA(ATA), .ATS(ATS), .AA1(AA1),
        .WDIDE(WDIDE), .DOUT(DOUT), .CPUTA(CPUTA), .BERR(BERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { bit err; logic [31:0] dout; } ev_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    logic [15:0] rd_q[$];
    bit          aa1_log[$];
    logic [15:0] wd_log[$];

    int ats_cnt = 0, cputa_cnt = 0, berr_cnt = 0, ata_cnt = 0;
    int ats_cyc = 0, cputa_cyc = 0, berr_cyc = 0, ata_cyc = 0;
    bit eng_on = 1'b1;
    int eng_lat = 2;

    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor: samples mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (ATS === 1'b0) begin
            ats_cnt++;
            ats_cyc = cyc;
            aa1_log.push_back(AA1);
            wd_log.push_back(WDIDE);
        end
        if (CPUTA === 1'b0 || BERR === 1'b0) begin
            checks++;
            assert (!(CPUTA === 1'b0 && BERR === 1'b0)) else begin
                failures++;
                $error("FAIL ack_berr_excl CPUTA=%b BERR=%b required not both low", CPUTA, BERR);
            end
            obs_q.push_back('{err: (BERR === 1'b0), dout: DOUT});
            if (CPUTA === 1'b0) begin cputa_cnt++; cputa_cyc = cyc; end
            if (BERR === 1'b0)  begin berr_cnt++;  berr_cyc  = cyc; end
        end
    end

    // Behavioural IDE timing engine: acknowledges eng_lat cycles after each strobe.
    initial begin
        ATA = 1'b1;
        DIDE = 16'h0;
        forever begin
            @(negedge CLK);
            if (eng_on && ATS === 1'b0) begin
                repeat (eng_lat) @(negedge CLK);
                if (rd_q.size() != 0) DIDE = rd_q.pop_front();
                ATA = 1'b0;
                ata_cyc = cyc;
                ata_cnt++;
                @(negedge CLK);
                ATA = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_cyc(input bit rw, input logic [31:0] a, input logic [1:0] siz,
                             input logic [31:0] d);
        @(negedge CLK);
        TS = 1'b0; ACCESS = 1'b0; RW = rw; A = a; SIZ = siz; D = d;
        @(negedge CLK);
        TS = 1'b1; ACCESS = 1'b1;
    endtask

    // Wait (bounded) for the DUT to finish, then score it against the queue.
    task automatic wait_obs(input string tag);
        int n = 0;
        ev_t o, e;
        while (obs_q.size() == 0 && n < 600) begin
            @(negedge CLK);
            n++;
        end
        if (obs_q.size() == 0) begin
            chk({tag, "_timeout"}, obs_q.size(), 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_err"}, 32'(o.err), 32'(e.err));
            chk({tag, "_dout"}, o.dout, e.dout);
        end
        repeat (3) @(negedge CLK);
    endtask

    int a0, c0, b0, n;

    initial begin
        RESET = 1'b1; TS = 1'b1; ACCESS = 1'b1; RW = 1'b0;
        A = 32'h0; SIZ = 2'b00; D = 32'h0;
        repeat (2) @(negedge CLK);
        chk("rst_ats", 32'(ATS), 1);
        chk("rst_cputa", 32'(CPUTA), 1);
        chk("rst_berr", 32'(BERR), 1);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_aa1", 32'(AA1), 0);
        chk("rst_wdide", 32'(WDIDE), 0);
        chk("rst_dout", DOUT, 0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Long read: two sub-cycles, high word first.
        a0 = ats_cnt; c0 = cputa_cnt; aa1_log.delete();
        rd_q.push_back(16'h1234); rd_q.push_back(16'h5678);
        exp_q.push_back('{err: 1'b0, dout: 32'h12345678});
        start_cyc(1'b1, 32'h00DA2000, 2'b00, 32'h0);
        wait_obs("long_rd");
        chk("long_rd_ats", ats_cnt - a0, 2);
        chk("long_rd_cputa", cputa_cnt - c0, 1);
        chk("long_rd_aa1_0", 32'(aa1_log[0]), 0);
        chk("long_rd_aa1_1", 32'(aa1_log[1]), 1);
        chk("long_rd_lat", cputa_cyc, ata_cyc + 1);

        // Word write to low word, with a stray TS while busy.
        a0 = ats_cnt; aa1_log.delete(); wd_log.delete(); eng_lat = 4;
        exp_q.push_back('{err: 1'b0, dout: 32'h12345678});
        start_cyc(1'b0, 32'h00DA2002, 2'b10, 32'hAAAA5555);
        TS = 1'b0; ACCESS = 1'b0;
        @(negedge CLK);
        TS = 1'b1; ACCESS = 1'b1;
        wait_obs("wr_word");
        chk("wr_word_ats", ats_cnt - a0, 1);
        chk("wr_word_aa1", 32'(aa1_log[0]), 1);
        chk("wr_word_wdide", 32'(wd_log[0]), 32'h5555);
        chk("wr_word_lat", cputa_cyc, ata_cyc + 1);
        chk("wr_word_extra", obs_q.size(), 0);
        eng_lat = 2;

        // Long write: high half then low half on WDIDE.
        a0 = ats_cnt; wd_log.delete();
        exp_q.push_back('{err: 1'b0, dout: 32'h12345678});
        start_cyc(1'b0, 32'h00DA2000, 2'b00, 32'hDEADBEEF);
        wait_obs("wr_long");
        chk("wr_long_ats", ats_cnt - a0, 2);
        chk("wr_long_wd0", 32'(wd_log[0]), 32'hDEAD);
        chk("wr_long_wd1", 32'(wd_log[1]), 32'hBEEF);

        // Byte read in upper word: single sub-cycle, low half untouched.
        a0 = ats_cnt; rd_q.push_back(16'h00CC);
        exp_q.push_back('{err: 1'b0, dout: 32'h00CC5678});
        start_cyc(1'b1, 32'h00DA2001, 2'b01, 32'h0);
        wait_obs("rd_byte");
        chk("rd_byte_ats", ats_cnt - a0, 1);

        // Misaligned word read (A[1]=0, A[0]=1) crosses the word boundary.
        a0 = ats_cnt; rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
        exp_q.push_back('{err: 1'b0, dout: 32'h11112222});
        start_cyc(1'b1, 32'h00DA2001, 2'b10, 32'h0);
        wait_obs("rd_mis");
        chk("rd_mis_ats", ats_cnt - a0, 2);

        // TS outside the IDE window is ignored.
        a0 = ats_cnt; c0 = cputa_cnt; b0 = berr_cnt;
        @(negedge CLK);
        TS = 1'b0; ACCESS = 1'b1; A = 32'h00DA2000; RW = 1'b1;
        @(negedge CLK);
        TS = 1'b1;
        chk("noacc_busy", 32'(BUSY), 0);
        repeat (5) @(negedge CLK);
        chk("noacc_ats", ats_cnt - a0, 0);
        chk("noacc_ack", (cputa_cnt - c0) + (berr_cnt - b0), 0);

        // Engine never answers: bus error 255 cycles after the strobe.
        eng_on = 1'b0; c0 = cputa_cnt; b0 = berr_cnt;
        exp_q.push_back('{err: 1'b1, dout: 32'h11112222});
        start_cyc(1'b1, 32'h00DA2000, 2'b00, 32'h0);
        wait_obs("tmo");
        chk("tmo_berr_cnt", berr_cnt - b0, 1);
        chk("tmo_cputa_cnt", cputa_cnt - c0, 0);
        chk("tmo_lat", berr_cyc - ats_cyc, 255);
        chk("tmo_idle", 32'(BUSY), 0);
        eng_on = 1'b1;

        // Acknowledge lands on the expiry cycle: completes normally.
        eng_lat = 254; b0 = berr_cnt; c0 = cputa_cnt;
        rd_q.push_back(16'h7777);
        exp_q.push_back('{err: 1'b0, dout: 32'h11117777});
        start_cyc(1'b1, 32'h00DA2002, 2'b10, 32'h0);
        wait_obs("edge");
        chk("edge_berr", berr_cnt - b0, 0);
        chk("edge_cputa", cputa_cnt - c0, 1);
        chk("edge_ata_cyc", ata_cyc - ats_cyc, 254);
        eng_lat = 2;

        // Reset during GAP of a long read aborts silently.
        a0 = ats_cnt; c0 = cputa_cnt; b0 = berr_cnt;
        rd_q.push_back(16'hABCD); rd_q.push_back(16'hEF01);
        start_cyc(1'b1, 32'h00DA2000, 2'b00, 32'h0);
        n = 0;
        while (AA1 !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        chk("gap_reached", 32'(AA1), 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("gap_rst_dout", DOUT, 0);
        chk("gap_rst_busy", 32'(BUSY), 0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        rd_q.delete();
        chk("gap_rst_ats", ats_cnt - a0, 1);
        chk("gap_rst_ack", (cputa_cnt - c0) + (berr_cnt - b0), 0);

        // Next transfer after the abort proceeds normally.
        rd_q.push_back(16'h9ABC);
        exp_q.push_back('{err: 1'b0, dout: 32'h00009ABC});
        start_cyc(1'b1, 32'h00DA2002, 2'b10, 32'h0);
        wait_obs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
